fp_add_arb_sched: RTL and testbench
===================================

// Module: fp_add_arb_sched
// PURPOSE
//  Shares one stall-able, fixed-latency IEEE single-precision adder (E8/M23, LAT-stage registered output
//  with an astall-style freeze) between NREQ requesters. Round-robin grants at most one op per cycle,
//  drives the adder operands and stall, tracks each op's owner in a tag pipe, and returns results.
//  Sits between the SFU front-end request ports and the shared fp_add instance.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  LAT    1   adder pipeline depth in cycles; tag pipe has exactly LAT stages
//  EXP_W  8   exponent width
//  MAN_W  23  mantissa width; FP_W = 1+EXP_W+MAN_W = 32
//  CNT_W  16  statistics counter width (FP_ADD_ARB_STATS_EN only)
// PORTS
//  aclk        in   1          clock
//  arst_n      in   1          asynchronous active-low reset
//  req_valid   in   NREQ       per-requester op valid
//  req_ready   out  NREQ       one-hot grant; op i is accepted when req_valid[i]&req_ready[i]
//  req_a       in   NREQ*FP_W  operand A, requester i at [i*FP_W +: FP_W]
//  req_b       in   NREQ*FP_W  operand B, same packing
//  req_rm      in   NREQ*3     rounding mode, same packing
//  add_a/add_b out  FP_W       operands to adder {sign,exp,man}; muxed from the granted requester
//  add_rm      out  3          rounding mode to adder
//  add_x       in   FP_W       adder result, valid LAT cycles after issue (stall cycles excluded)
//  add_stall   out  1          freezes adder pipe (connects to astall)
//  rsp_valid   out  NREQ       one-hot result valid to owner
//  rsp_ready   in   NREQ       per-requester result accept
//  rsp_x       out  FP_W       result data (shared bus, qualified by rsp_valid)
// BEHAVIOUR
//  - Reset (arst_n=0, async): tag pipe all invalid, output slot empty, rsp_valid=0, rsp_x=0,
//    RR pointer=NREQ-1 (req 0 wins first). req_ready=0 and add_stall=0 while in reset.
//    Reset mid-operation discards all in-flight ops; no response is ever produced for them.
//  - Output slot: one register {full, id, x}. rsp_valid = full ? onehot(id) : 0.
//  - add_stall = full & ~rsp_ready[id] (combinational). While stalled: no grant (req_ready=0),
//    tag pipe and slot hold, adder frozen; rsp_x stable.
//  - Grant (not stalled): search from ptr+1 upward, wrapping at NREQ-1->0, for first req_valid;
//    req_ready[g]=1, add_a/b/rm = requester g's fields, tag stage 0 <= {1,g}, ptr <= g.
//    No requester valid: tag stage 0 <= invalid, ptr unchanged, add_* = 0.
//  - Tag pipe shifts one stage per non-stalled cycle, in lockstep with the adder.
//  - Slot load (not stalled): tail tag valid -> slot <= {1, tail.id, add_x}; else slot <= empty
//    (if its content was accepted this cycle). Accept + new load in same cycle => no bubble.
//  - Latency: accept at cycle t -> rsp_valid at t+LAT+1 with zero stalls; +1 per stall cycle.
//  - Throughput: 1 op/cycle aggregate; results return in grant order; no reordering.
//  - Requester i may drop req_valid without accept; no state change. rsp_ready to non-owner ignored.
//  - Widths: ids are $clog2(NREQ) bits; no arithmetic on FP data inside this block.
// CONFIGURATION
//  FP_ADD_ARB_STATS_EN defined: adds ports stat_clr in 1, stat_sel in $clog2(NREQ)+1, stat_cnt out CNT_W.
//    Per-requester grant counters plus one stall-cycle counter (sel==NREQ); saturate at all-ones;
//    stat_clr synchronously zeroes all (clear wins over same-cycle increment); reset to 0.
//    stat_cnt is registered: reflects stat_sel of previous cycle.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package fp_add_arb_pkg: FP_W, rounding-mode constants (RNE=3'd0,RTZ,RDN,RUP,RMM),
//    typedef tag_t {logic vld; logic [ID_W-1:0] id;}, ID_W function.
//  Sub-module fp_add_arb_rr: round-robin picker (req vector, ptr, en -> onehot grant, idx, any).
//  Adder instance stays outside this block; connected by the integrator.
// TESTING
//  1 Single op: req0 a=0x3F800000 b=0x40000000 rm=RNE, rsp_ready=1 -> rsp_valid=4'b0001 at t+LAT+1, rsp_x=0x40400000.
//  2 Fairness: all 4 valid continuously, 8 ops each -> grant order 0,1,2,3,0,... ; every requester 8 results.
//  3 Backpressure: req2 result pending, rsp_ready[2]=0 for 5 cycles -> add_stall=1, req_ready=0,
//    rsp_x held 5 cycles; release -> remaining results follow in grant order, none lost or duplicated.
//  4 Back-to-back: req1 issues every cycle with rsp_ready=1 -> one rsp_valid per cycle, no bubbles.
//  5 Reset mid-flight: arst_n low with 2 ops in tag pipe -> rsp_valid=0 immediately; after release no stale response; req0 granted first.
//  6 STATS_EN: 3 grants to req3, 2 stall cycles -> stat_sel=3 gives 3, stat_sel=4 gives 2; stat_clr -> 0.

Source files
------------

// File: rtl/fp_add_arb_pkg.sv
// Shared types for the fp_add arbiter: FP width, rounding modes and the owner tag.
package fp_add_arb_pkg;
  localparam int FP_W = 32;
  localparam int ID_W = 3;

  typedef enum logic [2:0] {RNE = 3'd0, RTZ, RDN, RUP, RMM} rm_e;

  // Wide enough for up to 8 requesters; narrower designs zero-extend.
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fp_add_arb_sched_if.sv
// Requester-facing op/result bus of the shared adder scheduler.
interface fp_add_arb_sched_if import fp_add_arb_pkg::*; #(
  parameter int NREQ = 4,
  parameter int W    = FP_W
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][W-1:0]  req_a;
  logic [NREQ-1:0][W-1:0]  req_b;
  logic [NREQ-1:0][2:0]    req_rm;
  logic [NREQ-1:0]         rsp_valid;
  logic [NREQ-1:0]         rsp_ready;
  logic [W-1:0]            rsp_x;

  modport master (output req_valid, req_a, req_b, req_rm, rsp_ready,
                  input  req_ready, rsp_valid, rsp_x);
  modport slave  (input  req_valid, req_a, req_b, req_rm, rsp_ready,
                  output req_ready, rsp_valid, rsp_x);
endinterface

// File: rtl/fp_add_arb_rr.sv
// Round-robin picker: first requester strictly after ptr, wrapping, when enabled.
module fp_add_arb_rr #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  // Two passes: indices above ptr first, then the wrapped part up to ptr.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++)
      if (en && !any && req[i] && (i > int'(ptr))) begin
        any = 1'b1; gnt[i] = 1'b1; idx = IW'(i);
      end
    for (int i = 0; i < N; i++)
      if (en && !any && req[i] && (i <= int'(ptr))) begin
        any = 1'b1; gnt[i] = 1'b1; idx = IW'(i);
      end
  end
endmodule

// File: rtl/fp_add_arb_sched.sv
// Shares one stall-able fixed-latency FP adder among NREQ requesters.
// Optional FP_ADD_ARB_STATS_EN adds grant/stall counters with a registered readout.
module fp_add_arb_sched import fp_add_arb_pkg::*; #(
  parameter int NREQ  = 4,
  parameter int LAT   = 1,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 16
) (
  input  logic                     aclk,
  input  logic                     arst_n,
  fp_add_arb_sched_if.slave        bus,
  output logic [EXP_W+MAN_W:0]     add_a,
  output logic [EXP_W+MAN_W:0]     add_b,
  output logic [2:0]               add_rm,
  input  logic [EXP_W+MAN_W:0]     add_x,
  output logic                     add_stall
`ifdef FP_ADD_ARB_STATS_EN
  ,
  input  logic                     stat_clr,
  input  logic [$clog2(NREQ):0]    stat_sel,
  output logic [CNT_W-1:0]         stat_cnt
`endif
);
  localparam int FW = 1 + EXP_W + MAN_W;
  localparam int IW = id_w(NREQ);

  logic [IW-1:0]   ptr, g_idx;
  logic [NREQ-1:0] gnt;
  logic            any, stall;
  logic            slot_full;
  logic [ID_W-1:0] slot_id;
  logic [FW-1:0]   slot_x;
  tag_t            tag_pipe [LAT];
  tag_t            tail;

  assign bus.rsp_valid = slot_full ? (NREQ'(1) << slot_id) : '0;
  assign bus.rsp_x     = slot_x;
  // Owner not taking its result: freeze everything behind the slot.
  assign stall         = slot_full & ~|(bus.rsp_ready & bus.rsp_valid);
  assign add_stall     = stall;
  assign tail          = tag_pipe[LAT-1];

  fp_add_arb_rr #(.N(NREQ), .IW(IW)) u_rr (
    .req (bus.req_valid),
    .ptr (ptr),
    .en  (arst_n & ~stall),
    .gnt (gnt),
    .idx (g_idx),
    .any (any)
  );
  assign bus.req_ready = gnt;

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_rm = '0;
    if (any) begin
      add_a  = bus.req_a[g_idx];
      add_b  = bus.req_b[g_idx];
      add_rm = bus.req_rm[g_idx];
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      ptr <= IW'(NREQ - 1);
      for (int s = 0; s < LAT; s++) tag_pipe[s] <= '0;
      slot_full <= 1'b0;
      slot_id   <= '0;
      slot_x    <= '0;
    end else if (!stall) begin
      if (any) ptr <= g_idx;
      tag_pipe[0] <= tag_t'{vld: any, id: ID_W'(g_idx)};
      for (int s = 1; s < LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
      // Slot is either drained this cycle or empty, so a reload never drops data.
      slot_full <= tail.vld;
      if (tail.vld) begin
        slot_id <= tail.id;
        slot_x  <= add_x;
      end
    end
  end

`ifdef FP_ADD_ARB_STATS_EN
  logic [CNT_W-1:0] cnt [NREQ+1];

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 0; k <= NREQ; k++) cnt[k] <= '0;
      stat_cnt <= '0;
    end else begin
      for (int k = 0; k <= NREQ; k++) begin
        if (stat_clr)
          cnt[k] <= '0;
        else if (((k < NREQ) && any && (int'(g_idx) == k)) || ((k == NREQ) && stall))
          if (cnt[k] != '1) cnt[k] <= cnt[k] + CNT_W'(1);
      end
      stat_cnt <= (int'(stat_sel) <= NREQ) ? cnt[stat_sel] : '0;
    end
  end
`endif
endmodule

// File: tb/tb_fp_add_arb_sched.sv
// Directed bench for fp_add_arb_sched: round-robin table, latency, backpressure, reset, stats.
module tb_fp_add_arb_sched;
  import fp_add_arb_pkg::*;
  localparam int N   = 4;
  localparam int LAT = 1;

  logic aclk = 1'b0;
  logic arst_n = 1'b0;
  logic [31:0] add_a, add_b, add_x;
  logic [2:0]  add_rm;
  logic        add_stall;
`ifdef FP_ADD_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [2:0]  stat_sel = '0;
  logic [15:0] stat_cnt;
`endif

  fp_add_arb_sched_if #(.NREQ(N), .W(32)) bus ();

  fp_add_arb_sched #(.NREQ(N), .LAT(LAT), .EXP_W(8), .MAN_W(23), .CNT_W(16)) dut (
    .aclk      (aclk),
    .arst_n    (arst_n),
    .bus       (bus),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_rm    (add_rm),
    .add_x     (add_x),
    .add_stall (add_stall)
`ifdef FP_ADD_ARB_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_sel  (stat_sel),
    .stat_cnt  (stat_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Stand-in adder: exact for 1.0+2.0, otherwise a deterministic operand mix
  // so every result can be traced back to the op that produced it.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return a ^ {b[15:0], b[31:16]} ^ {29'd0, rm};
  endfunction

  logic [31:0] apipe [LAT];
  always @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      for (int s = 0; s < LAT; s++) apipe[s] <= '0;
    end else if (!add_stall) begin
      apipe[0] <= fadd(add_a, add_b, add_rm);
      for (int s = 1; s < LAT; s++) apipe[s] <= apipe[s-1];
    end
  end
  assign add_x = apipe[LAT-1];

  // Scoreboard: accepted ops queued in grant order, results must match in order.
  typedef struct { int id; logic [31:0] x; } exp_t;
  exp_t q[$];
  int   rsp_cnt [N];

  always @(negedge aclk) begin
    if (arst_n) begin
      if (bus.rsp_valid != '0) begin
        if (q.size() == 0) chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        else begin
          chk("rsp_owner", 32'(bus.rsp_valid), 32'(1) << q[0].id);
          chk("rsp_x", bus.rsp_x, q[0].x);
          if (bus.rsp_ready[q[0].id]) begin
            rsp_cnt[q[0].id]++;
            void'(q.pop_front());
          end
        end
      end
      for (int i = 0; i < N; i++)
        if (bus.req_valid[i] && bus.req_ready[i])
          q.push_back('{i, fadd(bus.req_a[i], bus.req_b[i], bus.req_rm[i])});
    end
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic set_ops(input int tagv);
    for (int i = 0; i < N; i++) begin
      bus.req_a[i]  = 32'h1000_0000 | (32'(i) << 12) | 32'(tagv);
      bus.req_b[i]  = 32'h2000_0000 | (32'(tagv) << 4);
      bus.req_rm[i] = 3'(i);
    end
  endtask

  task automatic do_reset;
    arst_n = 1'b0;
    bus.req_valid = '0;
    q.delete();
    repeat (2) @(posedge aclk);
    #1 arst_n = 1'b1;
  endtask

  task automatic drain(input string nm);
    bus.req_valid = '0;
    repeat (8) tick;
    chk(nm, 32'(q.size()), 32'd0);
  endtask

  typedef struct { logic [3:0] valid; logic [3:0] gnt; } vec_t;
  vec_t tv [13];

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ea, e2;
    tv[0]  = '{4'b1111, 4'b0001};  tv[1]  = '{4'b1111, 4'b0010};
    tv[2]  = '{4'b0101, 4'b0100};  tv[3]  = '{4'b0101, 4'b0001};
    tv[4]  = '{4'b0000, 4'b0000};  tv[5]  = '{4'b1000, 4'b1000};
    tv[6]  = '{4'b1001, 4'b0001};  tv[7]  = '{4'b0011, 4'b0010};
    tv[8]  = '{4'b0011, 4'b0001};  tv[9]  = '{4'b1100, 4'b0100};
    tv[10] = '{4'b0110, 4'b0010};  tv[11] = '{4'b0110, 4'b0100};
    tv[12] = '{4'b0010, 4'b0010};

    bus.req_valid = 4'b1111;
    bus.rsp_ready = 4'b1111;
    set_ops(0);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_x", bus.rsp_x, 32'd0);
    chk("reset_stall", 32'(add_stall), 32'd0);
    bus.req_valid = '0;
    @(posedge aclk);
    #1 arst_n = 1'b1;

    // Round-robin table from the reset pointer (req 0 first).
    for (int k = 0; k < 13; k++) begin
      bus.req_valid = tv[k].valid;
      set_ops(k + 1);
      @(negedge aclk);
      chk($sformatf("rr%0d_gnt", k), 32'(bus.req_ready), 32'(tv[k].gnt));
      ea = '0;
      for (int i = 0; i < N; i++) if (tv[k].gnt[i]) ea = bus.req_a[i];
      chk($sformatf("rr%0d_add_a", k), add_a, ea);
      tick;
    end
    drain("rr_drain");

    // Single op latency.
    bus.req_valid = 4'b0001;
    bus.req_a[0] = 32'h3F800000; bus.req_b[0] = 32'h40000000; bus.req_rm[0] = RNE;
    @(negedge aclk);
    chk("single_ready", 32'(bus.req_ready), 32'd1);
    tick;
    bus.req_valid = '0;
    @(negedge aclk);
    chk("single_early", 32'(bus.rsp_valid), 32'd0);
    tick;
    @(negedge aclk);
    chk("single_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_x", bus.rsp_x, 32'h40400000);
    drain("single_drain");

    // Fairness with everyone valid.
    do_reset;
    for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 32; k++) begin
      set_ops(k + 100);
      @(negedge aclk);
      chk("fair_gnt", 32'(bus.req_ready), 32'(1) << (k % 4));
      tick;
    end
    drain("fair_drain");
    for (int i = 0; i < N; i++) chk($sformatf("fair_cnt%0d", i), 32'(rsp_cnt[i]), 32'd8);

    // Backpressure on requester 2.
    bus.rsp_ready = 4'b1011;
    set_ops(200);
    e2 = fadd(bus.req_a[2], bus.req_b[2], bus.req_rm[2]);
    bus.req_valid = 4'b0100;
    @(negedge aclk);
    chk("bp_gnt2", 32'(bus.req_ready), 32'h4);
    tick;
    bus.req_valid = 4'b1001;
    @(negedge aclk);
    chk("bp_gnt3", 32'(bus.req_ready), 32'h8);
    tick;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      chk("bp_stall", 32'(add_stall), 32'd1);
      chk("bp_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'h4);
      chk("bp_rsp_x", bus.rsp_x, e2);
      tick;
    end
    bus.rsp_ready = 4'b1111;
    @(negedge aclk);
    chk("bp_release_stall", 32'(add_stall), 32'd0);
    chk("bp_release_gnt0", 32'(bus.req_ready), 32'h1);
    tick;
    drain("bp_drain");

    // Back-to-back from requester 1.
    for (int c = 0; c < 12; c++) begin
      bus.req_valid = (c < 10) ? 4'b0010 : 4'b0000;
      set_ops(300 + c);
      @(negedge aclk);
      if (c < 10) chk("b2b_gnt", 32'(bus.req_ready), 32'h2);
      if (c >= 2) chk("b2b_rsp", 32'(bus.rsp_valid), 32'h2);
      tick;
    end
    drain("b2b_drain");

    // Reset with one result in the slot and one op in the tag pipe.
    bus.req_valid = 4'b0110;
    set_ops(400);
    tick;
    tick;
    @(negedge aclk);
    chk("rst_inflight", 32'(bus.rsp_valid), 32'h4);
    #2 arst_n = 1'b0;
    q.delete();
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_stall", 32'(add_stall), 32'd0);
    repeat (2) @(posedge aclk);
    #1 arst_n = 1'b1;
    bus.req_valid = 4'b1111;
    @(negedge aclk);
    chk("rst_first_gnt", 32'(bus.req_ready), 32'h1);
    tick;
    drain("rst_drain");

`ifdef FP_ADD_ARB_STATS_EN
    do_reset;
    bus.rsp_ready = 4'b0111;
    bus.req_valid = 4'b1000;
    set_ops(500);
    for (int c = 0; c < 4; c++) begin
      @(negedge aclk);
      if (c < 2) chk("st_gnt", 32'(bus.req_ready), 32'h8);
      else       chk("st_stall", 32'(add_stall), 32'd1);
      tick;
    end
    bus.rsp_ready = 4'b1111;
    @(negedge aclk);
    chk("st_gnt3", 32'(bus.req_ready), 32'h8);
    tick;
    drain("st_drain");
    stat_sel = 3'd3;
    tick;
    @(negedge aclk);
    chk("stat_grants3", 32'(stat_cnt), 32'd3);
    stat_sel = 3'd4;
    tick;
    @(negedge aclk);
    chk("stat_stalls", 32'(stat_cnt), 32'd2);
    stat_clr = 1'b1;
    tick;
    stat_clr = 1'b0;
    tick;
    @(negedge aclk);
    chk("stat_clr", 32'(stat_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
